mul_add_result_hex_writer: RTL

Streaming transmitter that turns one fused multiply-add result record (operands a, b, c, result z, exception flags) into the ASCII hex line format consumed by the float-unit test flow, one byte per handshake. Each line is `AAAAAAAA BBBBBBBB CCCCCCCC ZZZZZZZZ FF` followed by a line feed. It is the hardware equivalent of the bench's per-result writes and sits between a mulAdd datapath (after recoded-to-standard conversion) and a byte sink such as a UART or trace FIFO.

---
 rtl/mul_add_result_hex_writer.sv | 119 +++++++++++
 1 files changed

// File: rtl/mul_add_result_hex_writer.sv
// Serialises one mulAdd result record (a, b, c, z, flags) into a 39-byte ASCII hex line.
// First byte one cycle after acceptance; a byte only advances on out_valid && out_ready.
module mul_add_result_hex_writer #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic [31:0]            in_c,
  input  logic [31:0]            in_z,
  input  logic [4:0]             in_flags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] record_count
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [5:0]  idx;
  logic [31:0] ra, rb, rc, rz;
  logic [4:0]  rf;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= 6'd0;
      record_count <= '0;
      ra           <= 32'd0;
      rb           <= 32'd0;
      rc           <= 32'd0;
      rz           <= 32'd0;
      rf           <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra    <= in_a;
            rb    <= in_b;
            rc    <= in_c;
            rz    <= in_z;
            rf    <= in_flags;
            idx   <= 6'd0;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx == 6'd38) begin
              record_count <= record_count + 1'b1;
              state        <= IDLE;
            end else begin
              idx <= idx + 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);

  logic [31:0] word;
  logic [2:0]  k;
  logic [3:0]  nib;
  logic        is_hex;
  logic [7:0]  ch;

  // Each word field ends on an index congruent to 7, 0, 1, 2 (mod 8), so the
  // nibble number is that constant minus the low three index bits.
  always_comb begin
    word   = ra;
    k      = 3'd0;
    nib    = 4'd0;
    is_hex = 1'b1;
    ch     = 8'h20;
    if (idx <= 6'd7) begin
      word = ra;
      k    = 3'd7 - idx[2:0];
    end else if (idx >= 6'd9 && idx <= 6'd16) begin
      word = rb;
      k    = 3'd0 - idx[2:0];
    end else if (idx >= 6'd18 && idx <= 6'd25) begin
      word = rc;
      k    = 3'd1 - idx[2:0];
    end else if (idx >= 6'd27 && idx <= 6'd34) begin
      word = rz;
      k    = 3'd2 - idx[2:0];
    end else begin
      is_hex = 1'b0;
    end
    nib = word[{k, 2'b00} +: 4];
    if (idx == 6'd36) begin
      nib    = {3'b000, rf[4]};
      is_hex = 1'b1;
    end else if (idx == 6'd37) begin
      nib    = rf[3:0];
      is_hex = 1'b1;
    end
    if (is_hex) begin
      ch = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end else if (idx == 6'd38) begin
      ch = 8'h0A;
    end else begin
      ch = 8'h20;
    end
  end

  assign out_data = (state == SEND) ? ch : 8'h00;

endmodule
